memory_cycle: RTL and testbench
===============================

Name: memory_cycle

Overview:
- MEM stage of the 5-stage RV32I pipeline. It sits between the execute stage and the writeback stage, which selects among ALU result, load data and PC+4.
- Holds the data memory and performs byte, half and word stores and loads, including sign and zero extension of loads.
- Registers all MEM/WB pipeline signals on each clock edge, so the writeback stage receives stable inputs for one full cycle.

Parameters:
- DMEM_WORDS, 1024, number of 32-bit words in data memory (power of two).
- ADDR_W, 10, word-index width; must equal log2(DMEM_WORDS).

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- RegWrite_M  in  1  register-file write enable from EX/MEM.
- MemWrite_M  in  1  data-memory store enable.
- ResultSrc_M  in  2  writeback select; passed through unchanged.
- funct3_M  in  3  load/store size and signedness.
- RD_M  in  5  destination register index.
- ALU_Result_M  in  32  effective byte address; also the ALU result passed to writeback.
- WriteData_M  in  32  store data (rs2).
- PCPlus4_M  in  32  PC+4 of this instruction.
- RegWrite_W  out  1  registered RegWrite_M.
- ResultSrc_W  out  2  registered ResultSrc_M.
- RD_W  out  5  registered RD_M.
- ALU_Result_W  out  32  registered ALU_Result_M.
- ReadData_W  out  32  registered, extended load data.
- PCPlus4_W  out  32  registered PCPlus4_M.
- MisalignErr_W  out  1  present only when MEM_MISALIGN_CHK_EN is defined.

Behaviour:
- Reset (rst=0, async):
  - All *_W outputs go to 0 immediately.
  - Memory array is not reset. It is zero-initialised at time 0 for simulation only.
  - Reset release is synchronous to the next rising clk edge.
  - Reset asserted mid-store: the store at that edge is dropped.
- Addressing:
  - Word index = ALU_Result_M[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo DMEM_WORDS*4.
  - Byte offset = ALU_Result_M[1:0].
- Store (MemWrite_M=1), synchronous write at the rising edge:
  - funct3 000 (SB): write WriteData_M[7:0] to the byte lane given by offset.
  - funct3 001 (SH): write WriteData_M[15:0] to lane pair offset[1] (bytes 1:0 or 3:2).
  - funct3 010 (SW): write the full word.
  - Any other funct3: no write.
  - Unwritten lanes keep their contents.
- Load read path:
  - The memory word is read combinationally in the M cycle.
  - Lane extraction per offset:
    - 000 LB: sign-extend byte.
    - 100 LBU: zero-extend byte.
    - 001 LH: sign-extend half.
    - 101 LHU: zero-extend half.
    - 010 LW: full word.
    - 011/110/111: 0.
  - The extracted value is registered into ReadData_W.
  - ReadData_W updates every cycle regardless of ResultSrc_M.
- Latency: every M input appears on its *_W output exactly 1 cycle later.
- Store then load, same address, back-to-back cycles: the load returns the newly stored data, because the write commits at the edge before the load's M cycle.
- A load and store to the same word cannot be in M in the same cycle; a single instruction never does both. If MemWrite_M=1, ReadData_W carries the pre-write word.
- Without MEM_MISALIGN_CHK_EN, misaligned accesses are silently truncated:
  - SH/LH/LHU ignore offset[0].
  - SW/LW ignore offset[1:0].

Optional Feature:
- Macro: MEM_MISALIGN_CHK_EN.
- When defined:
  - Port MisalignErr_W exists.
  - A halfword access with offset[0]=1, or a word access with offset!=0, is misaligned.
  - A misaligned store is suppressed (memory unchanged).
  - A misaligned load sets ReadData_W=0.
  - MisalignErr_W=1 for that instruction, registered with the same 1-cycle latency; reset value 0.
- When undefined: no port, no check, truncation behaviour as above.

Test Plan:
- Reset: drive inputs non-zero, pulse rst=0 mid-cycle -> all *_W = 0 immediately, with no clock edge required.
- Passthrough: RegWrite_M=1, ResultSrc_M=2'b10, RD_M=7, PCPlus4_M=0x104, ALU_Result_M=0x55 -> same values on *_W one edge later.
- SW 0xDEADBEEF @0x40, then LW @0x40 next cycle -> ReadData_W=0xDEADBEEF. Then LB @0x41 -> 0xFFFFFFBE; LBU @0x41 -> 0x000000BE.
- SB 0x12 @0x43 onto 0xDEADBEEF, then LW @0x40 -> 0x12ADBEEF. Then LH @0x42 -> 0x000012AD; LHU @0x40 -> 0x0000BEEF.
- Wrap: SW 0xA5A5A5A5 @ (DMEM_WORDS*4 + 0x8), then LW @0x8 -> 0xA5A5A5A5.
- MEM_MISALIGN_CHK_EN defined: SW 0x1 @0x41 -> word @0x40 unchanged, MisalignErr_W=1 for one cycle. LW @0x42 -> ReadData_W=0, MisalignErr_W=1.

Source files
------------

// File: rtl/memory_cycle.sv
// MEM stage: data memory with byte/half/word access and MEM/WB register.
// Optional misaligned-access checking under `define MEM_MISALIGN_CHK_EN.
module memory_cycle #(
   parameter int DMEM_WORDS = 1024,
   parameter int ADDR_W     = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWrite_M,
   input  logic        MemWrite_M,
   input  logic [1:0]  ResultSrc_M,
   input  logic [2:0]  funct3_M,
   input  logic [4:0]  RD_M,
   input  logic [31:0] ALU_Result_M,
   input  logic [31:0] WriteData_M,
   input  logic [31:0] PCPlus4_M,
`ifdef MEM_MISALIGN_CHK_EN
   output logic        MisalignErr_W,
`endif
   output logic        RegWrite_W,
   output logic [1:0]  ResultSrc_W,
   output logic [4:0]  RD_W,
   output logic [31:0] ALU_Result_W,
   output logic [31:0] ReadData_W,
   output logic [31:0] PCPlus4_W
);

   logic [31:0]       dmem [DMEM_WORDS];
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        off;
   logic [31:0]       rd_word;
   logic [31:0]       rd_shift;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic [31:0]       load_val;
   logic              mis;
   logic              unused_hi;

   // upper address bits wrap away
   assign unused_hi = ^ALU_Result_M[31:ADDR_W+2];

   assign word_idx = ALU_Result_M[ADDR_W+1:2];
   assign off      = ALU_Result_M[1:0];
   assign rd_word  = dmem[word_idx];
   assign rd_shift = rd_word >> {off, 3'b000};
   assign rd_byte  = rd_shift[7:0];
   assign rd_half  = off[1] ? rd_word[31:16]
                            : rd_word[15:0];

   // misaligned halfword / word detection
   always_comb begin
      mis = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
      if (funct3_M[1:0] == 2'b01 && off[0])
         mis = 1'b1;
      if (funct3_M == 3'b010 && off != 2'b00)
         mis = 1'b1;
`endif
   end

   // store lane enables and replicated store data
   always_comb begin
      be    = 4'b0000;
      wdata = WriteData_M;
      case (funct3_M)
         3'b000: begin
            be    = 4'b0001 << off;
            wdata = {4{WriteData_M[7:0]}};
         end
         3'b001: begin
            be    = off[1] ? 4'b1100 : 4'b0011;
            wdata = {2{WriteData_M[15:0]}};
         end
         3'b010: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      if (!MemWrite_M || mis)
         be = 4'b0000;
   end

   // load lane extraction and extension
   always_comb begin
      load_val = 32'h0;
      case (funct3_M)
         3'b000: load_val = {{24{rd_byte[7]}}, rd_byte};
         3'b100: load_val = {24'h0, rd_byte};
         3'b001: load_val = {{16{rd_half[15]}}, rd_half};
         3'b101: load_val = {16'h0, rd_half};
         3'b010: load_val = rd_word;
         default: load_val = 32'h0;
      endcase
      if (mis)
         load_val = 32'h0;
   end

   // byte-lane memory write; a store under reset is dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i])
               dmem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // MEM/WB pipeline register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWrite_W   <= 1'b0;
         ResultSrc_W  <= 2'b00;
         RD_W         <= 5'd0;
         ALU_Result_W <= 32'h0;
         ReadData_W   <= 32'h0;
         PCPlus4_W    <= 32'h0;
      end else begin
         RegWrite_W   <= RegWrite_M;
         ResultSrc_W  <= ResultSrc_M;
         RD_W         <= RD_M;
         ALU_Result_W <= ALU_Result_M;
         ReadData_W   <= load_val;
         PCPlus4_W    <= PCPlus4_M;
      end
   end

`ifdef MEM_MISALIGN_CHK_EN
   // misalignment flag, same latency as data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         MisalignErr_W <= 1'b0;
      else
         MisalignErr_W <= mis;
   end
`endif

endmodule

// File: tb/tb_memory_cycle.sv
// Testbench for memory_cycle: vector table plus scoreboard queue.
// Misalignment cases run only when MEM_MISALIGN_CHK_EN is defined.
module tb_memory_cycle;

   logic        clk;
   logic        rst;
   logic        RegWrite_M;
   logic        MemWrite_M;
   logic [1:0]  ResultSrc_M;
   logic [2:0]  funct3_M;
   logic [4:0]  RD_M;
   logic [31:0] ALU_Result_M;
   logic [31:0] WriteData_M;
   logic [31:0] PCPlus4_M;
   logic        RegWrite_W;
   logic [1:0]  ResultSrc_W;
   logic [4:0]  RD_W;
   logic [31:0] ALU_Result_W;
   logic [31:0] ReadData_W;
   logic [31:0] PCPlus4_W;
   logic        err_w;

   memory_cycle dut (
      .clk          (clk),
      .rst          (rst),
      .RegWrite_M   (RegWrite_M),
      .MemWrite_M   (MemWrite_M),
      .ResultSrc_M  (ResultSrc_M),
      .funct3_M     (funct3_M),
      .RD_M         (RD_M),
      .ALU_Result_M (ALU_Result_M),
      .WriteData_M  (WriteData_M),
      .PCPlus4_M    (PCPlus4_M),
`ifdef MEM_MISALIGN_CHK_EN
      .MisalignErr_W(err_w),
`endif
      .RegWrite_W   (RegWrite_W),
      .ResultSrc_W  (ResultSrc_W),
      .RD_W         (RD_W),
      .ALU_Result_W (ALU_Result_W),
      .ReadData_W   (ReadData_W),
      .PCPlus4_W    (PCPlus4_W)
   );

`ifndef MEM_MISALIGN_CHK_EN
   assign err_w = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic        rw;
      logic [1:0]  rs;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic        chk_rd;
      logic [31:0] rdata;
      logic [31:0] pc4;
      logic        err;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h",
                  nm, act, exp);
      end
   endtask

   task automatic add(input logic we,
                      input logic [2:0] f3,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic cr,
                      input logic [31:0] er,
                      input logic ee);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = a;
      v.wd = wd; v.chk_rd = cr;
      v.exp_rd = er; v.exp_err = ee;
      tbl.push_back(v);
   endtask

   // drive one M cycle, push expectation, check after the edge
   task automatic step(input logic rw,
                       input logic [1:0] rs,
                       input logic [4:0] rd,
                       input logic we,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [31:0] pc,
                       input logic cr,
                       input logic [31:0] er,
                       input logic ee);
      exp_t e;
      RegWrite_M = rw; ResultSrc_M = rs;
      RD_M = rd; MemWrite_M = we;
      funct3_M = f3; ALU_Result_M = a;
      WriteData_M = wd; PCPlus4_M = pc;
      e.rw = rw; e.rs = rs; e.rd = rd;
      e.alu = a; e.chk_rd = cr; e.rdata = er;
      e.pc4 = pc; e.err = ee;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard empty");
      end else begin
         e = sb.pop_front();
         chk("RegWrite_W", 32'(RegWrite_W), 32'(e.rw));
         chk("ResultSrc_W", 32'(ResultSrc_W), 32'(e.rs));
         chk("RD_W", 32'(RD_W), 32'(e.rd));
         chk("ALU_Result_W", ALU_Result_W, e.alu);
         chk("PCPlus4_W", PCPlus4_W, e.pc4);
         if (e.chk_rd)
            chk($sformatf("ReadData_W@%h", a),
                ReadData_W, e.rdata);
`ifdef MEM_MISALIGN_CHK_EN
         chk("MisalignErr_W", 32'(err_w), 32'(e.err));
`endif
      end
   endtask

   initial begin
      rst = 1'b0;
      RegWrite_M = 1'b0; MemWrite_M = 1'b0;
      ResultSrc_M = 2'b00; funct3_M = 3'b000;
      RD_M = 5'd0; ALU_Result_M = 32'h0;
      WriteData_M = 32'h0; PCPlus4_M = 32'h0;

      // vector table: we, f3, addr, wdata, chk, exp, err
      add(1, 3'b010, 32'h40, 32'hDEADBEEF, 0, 0, 0);
      add(0, 3'b010, 32'h40, 0, 1, 32'hDEADBEEF, 0);
      add(0, 3'b000, 32'h41, 0, 1, 32'hFFFFFFBE, 0);
      add(0, 3'b100, 32'h41, 0, 1, 32'h000000BE, 0);
      add(1, 3'b000, 32'h43, 32'h12, 1, 32'hFFFFFFDE, 0);
      add(0, 3'b010, 32'h40, 0, 1, 32'h12ADBEEF, 0);
      add(0, 3'b001, 32'h42, 0, 1, 32'h000012AD, 0);
      add(0, 3'b101, 32'h40, 0, 1, 32'h0000BEEF, 0);
      add(0, 3'b001, 32'h40, 0, 1, 32'hFFFFBEEF, 0);
      add(0, 3'b000, 32'h40, 0, 1, 32'hFFFFFFEF, 0);
      add(0, 3'b100, 32'h42, 0, 1, 32'h000000AD, 0);
      add(1, 3'b010, 32'h1008, 32'hA5A5A5A5, 0, 0, 0);
      add(0, 3'b010, 32'h8, 0, 1, 32'hA5A5A5A5, 0);
      add(1, 3'b010, 32'h44, 32'h0, 0, 0, 0);
      add(1, 3'b001, 32'h46, 32'h12347788, 1, 0, 0);
      add(0, 3'b010, 32'h44, 0, 1, 32'h77880000, 0);
      add(1, 3'b011, 32'h44, 32'hFFFFFFFF, 1, 0, 0);
      add(0, 3'b010, 32'h44, 0, 1, 32'h77880000, 0);
      add(0, 3'b101, 32'h46, 0, 1, 32'h00007788, 0);
      add(0, 3'b110, 32'h40, 0, 1, 32'h0, 0);
      add(0, 3'b111, 32'h40, 0, 1, 32'h0, 0);
`ifdef MEM_MISALIGN_CHK_EN
      add(1, 3'b010, 32'h41, 32'h1, 1, 32'h0, 1);
      add(0, 3'b010, 32'h40, 0, 1, 32'h12ADBEEF, 0);
      add(0, 3'b010, 32'h42, 0, 1, 32'h0, 1);
      add(0, 3'b001, 32'h41, 0, 1, 32'h0, 1);
      add(1, 3'b001, 32'h45, 32'hFFFF, 1, 32'h0, 1);
      add(0, 3'b010, 32'h44, 0, 1, 32'h77880000, 0);
`else
      add(0, 3'b010, 32'h43, 0, 1, 32'h12ADBEEF, 0);
      add(0, 3'b001, 32'h41, 0, 1, 32'hFFFFBEEF, 0);
      add(1, 3'b001, 32'h45, 32'h00003344, 0, 0, 0);
      add(0, 3'b010, 32'h44, 0, 1, 32'h77883344, 0);
      add(1, 3'b010, 32'h4B, 32'h01020304, 0, 0, 0);
      add(0, 3'b010, 32'h48, 0, 1, 32'h01020304, 0);
`endif

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset ReadData_W", ReadData_W, 32'h0);
      chk("reset PCPlus4_W", PCPlus4_W, 32'h0);
      chk("reset MisalignErr_W", 32'(err_w), 32'h0);
      rst = 1'b1;

      // passthrough
      step(1, 2'b10, 5'd7, 0, 3'b011, 32'h55, 32'h0,
           32'h104, 1, 32'h0, 0);

      // table-driven loads and stores
      foreach (tbl[i]) begin
         step(tbl[i].we, tbl[i].we ? 2'b00 : 2'b01,
              5'(i), tbl[i].we, tbl[i].f3,
              tbl[i].addr, tbl[i].wd,
              32'h1000 + 32'(i * 4),
              tbl[i].chk_rd, tbl[i].exp_rd,
              tbl[i].exp_err);
      end

      // async reset mid-cycle, no clock edge needed
      step(1, 2'b11, 5'd31, 0, 3'b010, 32'h40, 32'h0,
           32'hFFFFFFFC, 1, 32'h12ADBEEF, 0);
      #3;
      rst = 1'b0;
      #1;
      chk("async RegWrite_W", 32'(RegWrite_W), 32'h0);
      chk("async ResultSrc_W", 32'(ResultSrc_W), 32'h0);
      chk("async RD_W", 32'(RD_W), 32'h0);
      chk("async ALU_Result_W", ALU_Result_W, 32'h0);
      chk("async ReadData_W", ReadData_W, 32'h0);
      chk("async PCPlus4_W", PCPlus4_W, 32'h0);

      // store attempted while in reset is dropped
      MemWrite_M = 1'b1; funct3_M = 3'b010;
      ALU_Result_M = 32'h40; WriteData_M = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      chk("held RD_W", 32'(RD_W), 32'h0);
      MemWrite_M = 1'b0;
      rst = 1'b1;
      step(1, 2'b01, 5'd3, 0, 3'b010, 32'h40, 32'h0,
           32'h200, 1, 32'h12ADBEEF, 0);

      // back-to-back store then load
      step(0, 2'b00, 5'd0, 1, 3'b010, 32'h3FC,
           32'hCAFEF00D, 32'h204, 0, 0, 0);
      step(1, 2'b01, 5'd9, 0, 3'b010, 32'h3FC, 32'h0,
           32'h208, 1, 32'hCAFEF00D, 0);

      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard leftover %0d", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
